rom_fetch_sequencer: RTL

//  Instruction-fetch controller for the combinational program ROM (16-bit address in, 28-bit word out).

---
 rtl/rom_fetch_sequencer_pkg.sv | 21 ++
 rtl/rom_fetch_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rom_fetch_sequencer_pkg.sv
// ============================================================================
// Module : rom_fetch_sequencer_pkg
// Brief  : Shared opcode constants and fetch-state encoding for the fetch path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rom_fetch_sequencer_pkg;

  localparam logic [7:0] OPC_NOP   = 8'h00;
  localparam int         CNT_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/rom_fetch_sequencer.sv
// ============================================================================
// Module : rom_fetch_sequencer
// Brief  : PC owner and one-entry instruction slot for the combinational
//          program ROM, with branch redirect and NOP-operand fetch stalls.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rom_fetch_sequencer
  import rom_fetch_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [7:0]            NOP_OPCODE  = OPC_NOP
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iEnable,
  output logic [ADDR_WIDTH-1:0]  oRomAddress,
  input  logic [INSTR_WIDTH-1:0] iRomInstruction,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic [ADDR_WIDTH-1:0]  oPC,
  output logic                   oInstrValid,
  input  logic                   iInstrReady,
  input  logic                   iBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
  output logic                   oBusy
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

  fetch_state_e            r_state;
  fetch_state_e            w_state_next;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic [ADDR_WIDTH-1:0]   r_instr_pc;
  logic                    r_valid;
  logic [CNT_WIDTH-1:0]    r_count;

  logic                    w_slot_free;
  logic                    w_capture;
  logic                    w_stall;
  logic [7:0]              w_opcode;
  logic [CNT_WIDTH-1:0]    w_operand;

  // Opcode and operand fields overlap in bits [23:20] of the word.
  assign w_opcode    = iRomInstruction[INSTR_WIDTH-1 -: 8];
  assign w_operand   = iRomInstruction[CNT_WIDTH-1:0];
  assign w_slot_free = !r_valid || iInstrReady;
  assign w_capture   = (r_state == ST_FETCH) && iEnable && w_slot_free && !iBranchTaken;
  assign w_stall     = w_capture && (w_opcode == NOP_OPCODE) && (w_operand != '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (iBranchTaken) begin
      w_state_next = iEnable ? ST_FETCH : ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (iEnable) w_state_next = ST_FETCH;
        end
        ST_FETCH: begin
          if (!iEnable)    w_state_next = ST_IDLE;
          else if (w_stall) w_state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (!iEnable)               w_state_next = ST_IDLE;
          else if (r_count <= CNT_ONE) w_state_next = ST_FETCH;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pc <= RESET_PC;
    end else if (iBranchTaken) begin
      r_pc <= iBranchTarget;
    end else if (w_capture) begin
      r_pc <= r_pc + PC_ONE;
    end
  end

  // Branch flushes even an unaccepted word; drain only when nothing refills.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else if (iBranchTaken) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr    <= iRomInstruction;
      r_instr_pc <= r_pc;
      r_valid    <= 1'b1;
    end else if (r_valid && iInstrReady) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else if (iBranchTaken) begin
      r_count <= '0;
    end else if (w_stall) begin
      r_count <= w_operand;
    end else if (r_state == ST_WAIT) begin
      r_count <= (iEnable && (r_count > CNT_ONE)) ? (r_count - CNT_ONE) : '0;
    end
  end

  assign oRomAddress  = r_pc;
  assign oInstruction = r_instr;
  assign oPC          = r_instr_pc;
  assign oInstrValid  = r_valid;
  assign oBusy        = (r_state == ST_FETCH) || (r_state == ST_WAIT);

endmodule

`default_nettype wire
